// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        RECOVER
    } uart_rx_state_t;

    // Expected parity bit for a data word (zero-extended to 9 bits).
    function automatic logic parity_bit(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign pop_ok  = pop && !empty;
    // A pop in the same clock frees a slot, so a push into a full FIFO still lands.
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver feeding a FWFT receive FIFO, with sticky error flags.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = 80,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rxd,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    input  logic                          err_clr,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun_err,
    output logic                          busy,
    output logic                          rx_start,
    output logic                          rx_step,
    output logic                          rx_stop
);
    localparam int              CNT_W   = $clog2(CLK_PER_BIT);
    localparam int              HALF    = CLK_PER_BIT / 2;
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(CLK_PER_BIT - 1);

    uart_rx_state_t         state;
    logic                   rxd_meta;
    logic                   rxd_s;
    logic [CNT_W-1:0]       cnt;
    logic [3:0]             bit_idx;
    logic [1:0]             stop_idx;
    logic                   par_pend;
    logic                   stop_bad;
    logic [DATA_BITS-1:0]   shift;
    logic                   bit_tick;
    logic                   last_stop;
    logic                   push;

    assign bit_tick  = (cnt == LAST);
    assign last_stop = (stop_idx == 2'(STOP_BITS - 1));
    assign push      = (state == STOP) && bit_tick && last_stop && rxd_s && !stop_bad && !par_pend;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            stop_idx    <= '0;
            par_pend    <= 1'b0;
            stop_bad    <= 1'b0;
            shift       <= '0;
            rx_start    <= 1'b0;
            rx_step     <= 1'b0;
            rx_stop     <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            rx_start <= 1'b0;
            rx_step  <= 1'b0;
            rx_stop  <= 1'b0;
            cnt      <= bit_tick ? '0 : cnt + 1'b1;
            // Clear first so an error raised in the same clock wins.
            if (err_clr) begin
                frame_err   <= 1'b0;
                parity_err  <= 1'b0;
                overrun_err <= 1'b0;
            end
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rxd_s) state <= START;
                end
                START: begin
                    if (cnt == HALF_M1) begin
                        cnt <= '0;
                        if (!rxd_s) begin
                            state    <= DATA;
                            rx_start <= 1'b1;
                            bit_idx  <= '0;
                            stop_idx <= '0;
                            par_pend <= 1'b0;
                            stop_bad <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        shift   <= {rxd_s, shift[DATA_BITS-1:1]};
                        rx_step <= 1'b1;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 4'(DATA_BITS - 1)) begin
                            state <= (PARITY_EN != 0) ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (bit_tick) begin
                        rx_step  <= 1'b1;
                        par_pend <= (rxd_s != parity_bit(9'(shift), PARITY_ODD != 0));
                        state    <= STOP;
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        stop_idx <= stop_idx + 1'b1;
                        if (!rxd_s) stop_bad <= 1'b1;
                        if (last_stop) begin
                            if (!rxd_s || stop_bad) begin
                                frame_err <= 1'b1;
                                state     <= RECOVER;
                            end else if (par_pend) begin
                                parity_err <= 1'b1;
                                state      <= IDLE;
                            end else begin
                                rx_stop <= 1'b1;
                                if (full && !rd_en) overrun_err <= 1'b1;
                                state <= IDLE;
                            end
                        end
                    end
                end
                RECOVER: begin
                    if (rxd_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (shift),
        .pop       (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .count     (count)
    );

endmodule
